// File: rtl/mul_pair_issuer.sv
// Operand sequencer for the half-speed pair multiplier: buffers packed operand pairs,
// issues them as whole two-cycle en bursts and collects the sums into a credit-guarded FIFO.
module mul_pair_issuer #(
  parameter int ODEPTH = 4,
  parameter int RDEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [15:0] s_data,
  output logic       mul_en,
  output logic [3:0] mul1,
  output logic [3:0] mul2,
  input  logic       res_en,
  input  logic [8:0] res,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [8:0] m_data,
  output logic       err
);

  localparam int OAW = $clog2(ODEPTH);
  localparam int RAW = $clog2(RDEPTH);
  localparam int CW  = RAW + 1;
  localparam logic [OAW:0] ODEPTH_C = (OAW+1)'(ODEPTH);
  localparam logic [OAW:0] OTWO     = (OAW+1)'(2);
  localparam logic [CW-1:0] RDEPTH_C = CW'(RDEPTH);
  localparam logic [CW:0]   RDEPTH_W = (CW+1)'(RDEPTH);

  typedef enum logic [1:0] {IDLE, P0, P1} state_t;

  state_t state, next_state;

  logic [15:0]    omem [ODEPTH];
  logic [OAW-1:0] owr, ord, ord_plus1;
  logic [OAW:0]   ocount;
  logic           op_push, op_pop;

  logic [8:0]     rmem [RDEPTH];
  logic [RAW-1:0] rwr, rrd;
  logic [CW-1:0]  rcount, outstanding;
  logic           r_full, r_push, r_pop;

  logic           ops_ok, credit_ok, can_issue, issue;
  logic [CW:0]    inflight;
  logic [15:0]    issue_word;
  logic           mul_en_d;
  logic [3:0]     mul1_d, mul2_d;

  assign s_ready   = ocount < ODEPTH_C;
  assign op_push   = s_valid & s_ready;
  assign op_pop    = (state == P1);
  assign ord_plus1 = ord + 1'b1;

  always_ff @(posedge clk) begin
    if (op_push) omem[owr] <= s_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      owr    <= '0;
      ord    <= '0;
      ocount <= '0;
    end else begin
      if (op_push) owr <= owr + 1'b1;
      if (op_pop)  ord <= ord + 1'b1;
      case ({op_push, op_pop})
        2'b10:   ocount <= ocount + 1'b1;
        2'b01:   ocount <= ocount - 1'b1;
        default: ocount <= ocount;
      endcase
    end
  end

  // In P1 the head is leaving this cycle, so a follow-on burst needs a second entry.
  assign ops_ok    = (state == P1) ? (ocount >= OTWO) : (ocount != '0);
  assign inflight  = {1'b0, rcount} + {1'b0, outstanding};
  assign credit_ok = inflight < RDEPTH_W;
  assign can_issue = ops_ok & credit_ok;
  assign issue     = (next_state == P0);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      mul_en <= 1'b0;
      mul1   <= '0;
      mul2   <= '0;
    end else begin
      state  <= next_state;
      mul_en <= mul_en_d;
      mul1   <= mul1_d;
      mul2   <= mul2_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (can_issue) next_state = P0;
      P0:      next_state = P1;
      P1:      next_state = can_issue ? P0 : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    mul_en_d   = 1'b0;
    mul1_d     = '0;
    mul2_d     = '0;
    issue_word = (state == P1) ? omem[ord_plus1] : omem[ord];
    case (next_state)
      P0: begin
        mul_en_d = 1'b1;
        mul1_d   = issue_word[3:0];
        mul2_d   = issue_word[7:4];
      end
      P1: begin
        mul_en_d = 1'b1;
        mul1_d   = omem[ord][11:8];
        mul2_d   = omem[ord][15:12];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      outstanding <= '0;
    end else begin
      case ({issue, res_en})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
    end
  end

  assign r_full  = (rcount == RDEPTH_C);
  assign r_push  = res_en & ~r_full;
  assign r_pop   = m_valid & m_ready;
  assign m_valid = (rcount != '0);
  assign m_data  = m_valid ? rmem[rrd] : '0;

  always_ff @(posedge clk) begin
    if (r_push) rmem[rwr] <= res;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rwr    <= '0;
      rrd    <= '0;
      rcount <= '0;
    end else begin
      if (r_push) rwr <= rwr + 1'b1;
      if (r_pop)  rrd <= rrd + 1'b1;
      case ({r_push, r_pop})
        2'b10:   rcount <= rcount + 1'b1;
        2'b01:   rcount <= rcount - 1'b1;
        default: rcount <= rcount;
      endcase
    end
  end

  // Sticky until reset: unexpected result or a result with nowhere to go.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      err <= 1'b0;
    end else if (res_en && ((outstanding == '0) || r_full)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: doc/mul_pair_issuer.md
# mul_pair_issuer

Operand-side sequencer for the low-power half-speed pair multiplier, which sums two 4x4 products per two-cycle `en` burst. The block accepts packed operand-pair transactions from a valid/ready source and buffers them. It drives the multiplier's `en`/`mul1`/`mul2` inputs strictly in whole two-cycle pairs, then collects the returned `dout_en`/`dout` results into a credit-protected result FIFO with valid/ready output.

## Interface
- `ODEPTH`, 4: operand FIFO depth in transactions (power of 2, ≥2).
- `RDEPTH`, 4: result FIFO depth (power of 2, ≥2); also the credit limit.
- `clk` in 1: single clock (200 MHz).
- `rstn` in 1: reset. One clock; reset is synchronous and active-low.
- `s_valid` in 1: operand transaction valid.
- `s_ready` out 1: operand FIFO not full.
- `s_data` in 16: packing is {b1[15:12], a1[11:8], b0[7:4], a0[3:0]}.
- `mul_en` out 1: to multiplier `en`.
- `mul1` out 4: to multiplier `mul1`.
- `mul2` out 4: to multiplier `mul2`.
- `res_en` in 1: from multiplier `dout_en`.
- `res` in 9: from multiplier `dout`.
- `m_valid` out 1: result FIFO not empty.
- `m_ready` in 1: result consumer ready.
- `m_data` out 9: a0*b0 + a1*b1, range 0..450.
- `err` out 1: sticky protocol error.

## Operation
- **Operand FIFO:**
  - Write on `s_valid & s_ready`.
  - `s_ready` = registered count < ODEPTH.
  - The entry is visible to the FSM the cycle after the write.
- **Issue FSM:** states IDLE, P0, P1. All of `mul_en`, `mul1` and `mul2` are registered outputs.
  - IDLE: `mul_en`=0, `mul1`=`mul2`=0.
  - P0: `mul_en`=1, drives a0/b0 of the head entry.
  - P1: `mul_en`=1, drives a1/b1 of the head entry. The head is popped on P1 exit.
  - `can_issue` = operand FIFO non-empty AND (rcount + outstanding < RDEPTH), using registered values.
  - In P1, "non-empty" means at least 2 entries, because the current head is being popped.
  - IDLE→P0 when `can_issue`; otherwise stay in IDLE.
  - P0→P1 unconditionally. A started pair is never aborted.
  - P1→P0 when `can_issue` (back-to-back bursts, `mul_en` stays high); otherwise P1→IDLE.
- **Outstanding counter:**
  - +1 on every transition into P0.
  - −1 on `res_en`.
  - Both in the same cycle: net 0.
- **Result FIFO:**
  - Push `res` on `res_en`.
  - Pop on `m_valid & m_ready`.
  - Push and pop in the same cycle are both performed.
  - Credit accounting guarantees no overflow. A push when full is still guarded: the data is dropped and `err` is set.
- **`err`** is set by either of:
  - `res_en` while outstanding == 0;
  - a result FIFO push while full.
  - `err` clears only on reset.
- **Widths:** outstanding and rcount are clog2(RDEPTH)+1 bits. `res` is stored unmodified; the block does no arithmetic on the data.

## Timing
- **Reset values:**
  - `s_ready`=1, `mul_en`=0, `mul1`=`mul2`=0, `m_valid`=0, `m_data`=0, `err`=0.
  - FSM = IDLE.
  - All counts 0; both FIFOs empty.
- **Multiplier contract:**
  - For P0 in cycle T, `res_en`=1 with the sum in cycle T+2.
  - `mul_en` is always high for an even number of consecutive cycles, so a dangling single-product burst is never produced.
- **Latency with empty pipeline and `m_ready`=1:**
  - s handshake in cycle W → P0 in W+2, P1 in W+3.
  - `res_en` in W+4, `m_valid` in W+5.
- **Throughput:**
  - One transaction per 2 cycles, sustained while `m_ready`=1.
  - RDEPTH=4 does not throttle at full rate.
- **Backpressure:**
  - With `m_ready`=0, at most RDEPTH pairs are issued.
  - The FSM then stays in IDLE until credit frees. A freed credit is seen one cycle after the pop.
- **Simultaneous events:** operand write and pop in the same cycle keep the count unchanged. `s_ready` is based on the registered count, so a full FIFO that pops this cycle still shows `s_ready`=0.
- **Reset mid-burst:** `rstn` low in P0 or P1 forces IDLE and clears `mul_en` on the next edge. The multiplier must share the same reset. A stray `res_en` after reset sets `err`.

## Test plan
- **Single transaction:** s_data = {2,7,5,3} (a0=3, b0=5, a1=7, b1=2), handshake in cycle W.
  - `mul_en` high in W+2..W+3 with `mul1`/`mul2` = 3/5 then 7/2.
  - `m_valid` in W+5 with `m_data`=29.
- **Max operands:** all nibbles 15 → `m_data`=450.
- **Back-to-back stream, `m_ready`=1:**
  - Feed 8 transactions back-to-back.
  - `mul_en` stays continuously high for 16 cycles.
  - 8 results arrive in order, one every 2 cycles.
- **Backpressure:** `m_ready`=0, push 6 transactions.
  - Exactly 4 pairs issue; `m_valid` is held and `s_ready` drops when the operand FIFO fills.
  - Raise `m_ready`: the remaining 2 issue and all 6 drain in order.
- **Spurious result:** pulse `res_en` in IDLE with outstanding=0 → `err`=1 and stays set until `rstn`=0.
- **Reset mid-burst:** assert `rstn`=0 during P0.
  - Next cycle: `mul_en`=0, `s_ready`=1, `m_valid`=0, `err`=0.
  - A fresh transaction afterwards completes with the correct sum.
